morse_key_ctrl: RTL and testbench
=================================

# morse_key_ctrl

Sequencer that turns a single Morse key input into the element pattern and element count consumed by the 7-segment Morse letter decoder. It times key presses to classify each press as dot or dash, and packs the elements into a 4-bit code. It detects the inter-letter gap, and pulses a completion strobe when a letter is finished. It sits between the board push-button and the decoder's code/length inputs.

## Interface
- DASH_CYCLES, 25_000_000: press length (cycles) at or above which an element is a dash.
- GAP_CYCLES, 50_000_000: release length (cycles) that ends a letter.
- DEB_CYCLES, 500_000: debounce stability window (used only with MORSE_DEBOUNCE_EN).
- CNT_W, 27: width of the duration counter; must hold max(DASH_CYCLES, GAP_CYCLES, DEB_CYCLES).
- clk  in  1  system clock; sole clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- key  in  1  raw Morse key, asynchronous, 1 = pressed.
- code  out  4  element pattern to decoder pattern input; element i in bit i (dot=0, dash=1); unused bits 0.
- len  out  3  element count 0–4 to decoder length input; 0 = blank display.
- done  out  1  one-cycle pulse when a letter completes.
- err  out  1  sticky: current letter exceeded 4 elements.

## Operation
- Input conditioning: key → 2-FF synchronizer → key_s. Then, optionally, a debounce filter produces key_f (see Configuration).
- State machine: IDLE, PRESS, GAP. A single counter `cnt` saturates at all-ones.
- IDLE
  - Outputs hold the last completed letter.
  - On key_f=1:
    - clear code, len and err;
    - set cnt=1;
    - go to PRESS.
- PRESS
  - While key_f=1, cnt increments.
  - On the first cycle with key_f=0:
    - element = (cnt >= DASH_CYCLES);
    - if len<4, write code[len]=element and len=len+1;
    - if len==4, set err=1 and force len=0, leaving code unchanged;
    - then set cnt=1 and go to GAP.
- GAP
  - While key_f=0, cnt increments.
  - If key_f=1 while cnt<GAP_CYCLES: set cnt=1 and go to PRESS. The letter continues and code/len are not cleared.
  - When cnt reaches GAP_CYCLES: assert done for one cycle and go to IDLE.
- Overflow
  - With err set, further presses in the same letter keep len=0 and err=1.
  - done still pulses at letter end.
  - err clears only when the next letter starts from IDLE.
- Decoder view: code/len update live after each element, so the decoder shows the partial letter while it is keyed.

## Timing
- Reset values: state=IDLE, code=0000, len=000, done=0, err=0, cnt=0, synchronizer and filter registers=0.
- Press duration D = number of consecutive cycles key_f=1.
  - D >= DASH_CYCLES → dash; otherwise dot.
- code/len/err are registered. They change on the clock edge that samples the first key_f=0 cycle after a press.
- done is high for exactly one cycle. It occurs on the edge where the GAP_CYCLES-th consecutive low cycle is sampled; state is IDLE on the following cycle.
- Latency key→key_s is 2 cycles.
- Simultaneous events: a rise on the same cycle cnt would reach GAP_CYCLES counts as a press. The letter continues and no done is issued.
- Reset asserted mid-letter abandons it: no done, and outputs return to reset values on the next edge.
- A key held through reset release is treated as a fresh press starting after the synchronizer latency.

## Configuration
- MORSE_DEBOUNCE_EN defined:
  - key_f changes only after key_s has differed from key_f for DEB_CYCLES consecutive cycles;
  - a separate counter is used, and key_f lags key_s by DEB_CYCLES cycles.
- MORSE_DEBOUNCE_EN undefined:
  - key_f = key_s;
  - DEB_CYCLES is unused and no debounce logic is built.

## Test plan
All scenarios use DASH_CYCLES=8, GAP_CYCLES=16, DEB_CYCLES=4.

- **E:** press 3 cycles, release → code=0000 len=1 after release; done pulses 16 low cycles later; err=0.
- **N:** press 10, release 5, press 3, release → len 1 then 2; final code=0001, len=2; single done.
- **B then new letter:** press 10, 3, 3, 3 with 5-cycle gaps → code=0001, len=4, done. Next press clears to code=0000, len=0 before its first element.
- **Boundaries:**
  - press 7 → dot; press 8 → dash;
  - gap 15 then press → same letter;
  - gap 16 → done, then new letter.
- **Overflow and reset:**
  - five 3-cycle presses → after 5th, len=0 and err=1; done pulses; err holds until the next press from IDLE.
  - rst_n low mid-press → all outputs 0 next cycle, no done.
- **Debounce:**
  - with MORSE_DEBOUNCE_EN, a 3-cycle glitch causes no change;
  - without it, the same glitch yields a dot (len=1).

Source files
------------

// File: rtl/morse_key_ctrl.sv
// Purpose : times presses of a single Morse key and packs them into an element code/count
// Latency : key -> FSM 2 cycles (+DEB_CYCLES with debounce); code/len update 1 cycle after release is seen
// Backpressure: none; the key cannot be stalled, and code/len/err are live levels with done as a 1-cycle pulse
//
// Ports:
//   clk   in   system clock, sole domain
//   rst_n in   synchronous active-low reset
//   key   in   raw Morse key, asynchronous, 1 = pressed
//   code  out  element pattern, element i in bit i (dot=0, dash=1), unused bits 0
//   len   out  element count 0..4 (0 blanks the decoder display)
//   done  out  one-cycle pulse when the inter-letter gap ends a letter
//   err   out  sticky overflow flag: the letter had more than 4 elements
//
// Optional build macro: MORSE_DEBOUNCE_EN adds a stability filter between the
// synchronizer and the timing FSM. Without it the synchronized key drives the
// FSM directly and DEB_CYCLES only takes part in the counter width check.

module morse_key_ctrl #(
  parameter int unsigned DASH_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES  = 50_000_000,
  parameter int unsigned DEB_CYCLES  = 500_000,
  parameter int unsigned CNT_W       = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key,
  output logic [3:0] code,
  output logic [2:0] len,
  output logic       done,
  output logic       err
);

  // ---------------------------------------------------------------------------
  // Elaboration-time sanity check: the shared duration counter must be able to
  // represent every threshold it is compared against.
  // ---------------------------------------------------------------------------
  localparam int unsigned MAX_DG  = (DASH_CYCLES > GAP_CYCLES) ? DASH_CYCLES : GAP_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_DG > DEB_CYCLES) ? MAX_DG : DEB_CYCLES;
  localparam int unsigned CNT_MAX = (CNT_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << CNT_W) - 32'd1);

  if (MAX_CYC > CNT_MAX) begin : g_cnt_w_too_small
    $error("morse_key_ctrl: CNT_W too narrow for the configured cycle thresholds");
  end

  localparam logic [CNT_W-1:0] DASH_TH = CNT_W'(DASH_CYCLES);
  localparam logic [CNT_W-1:0] GAP_TH  = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer: key is asynchronous to clk.
  // ---------------------------------------------------------------------------
  logic key_m_q, key_m_d;
  logic key_s_q, key_s_d;
  logic key_f;

  always_comb begin
    key_m_d = key;
    key_s_d = key_m_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_m_q <= 1'b0;
      key_s_q <= 1'b0;
    end else begin
      key_m_q <= key_m_d;
      key_s_q <= key_s_d;
    end
  end

`ifdef MORSE_DEBOUNCE_EN
  // ---------------------------------------------------------------------------
  // Debounce: the filtered level follows key_s only after key_s has disagreed
  // with it for DEB_CYCLES consecutive cycles. Any agreeing cycle restarts the
  // window, so short glitches never reach the timing FSM.
  // ---------------------------------------------------------------------------
  logic             key_f_q, key_f_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;

  always_comb begin
    key_f_d   = key_f_q;
    deb_cnt_d = '0;
    if (key_s_q != key_f_q) begin
      if (deb_cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        key_f_d   = key_s_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_f_q   <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      key_f_q   <= key_f_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign key_f = key_f_q;
`else
  assign key_f = key_s_q;
`endif

  // ---------------------------------------------------------------------------
  // Timing FSM. One counter serves both phases: in PRESS it measures the press
  // length (already 1 on entry because the entering cycle was a high sample),
  // in GAP it measures the release length (1 on entry for the same reason).
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       code_q, code_d;
  logic [2:0]       len_q, len_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             elem;

  // Saturating increment so an endless press or release can never wrap back
  // below a threshold.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : (cnt_q + CNT_ONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    len_d   = len_q;
    err_d   = err_q;
    done_d  = 1'b0;
    elem    = (cnt_q >= DASH_TH);

    case (state_q)
      IDLE: begin
        // Outputs keep showing the last letter until a new one begins.
        if (key_f) begin
          code_d  = 4'b0000;
          len_d   = 3'd0;
          err_d   = 1'b0;
          cnt_d   = CNT_ONE;
          state_d = PRESS;
        end
      end

      PRESS: begin
        if (key_f) begin
          cnt_d = cnt_inc;
        end else begin
          // Once a letter has overflowed, every later element of that letter
          // keeps it in the overflow state and leaves code untouched.
          if (err_q || (len_q == 3'd4)) begin
            err_d = 1'b1;
            len_d = 3'd0;
          end else begin
            code_d[len_q[1:0]] = elem;
            len_d              = len_q + 3'd1;
          end
          cnt_d   = CNT_ONE;
          state_d = GAP;
        end
      end

      GAP: begin
        // A press wins over the gap timeout on the same cycle: the letter
        // continues and no done is issued.
        if (key_f) begin
          cnt_d   = CNT_ONE;
          state_d = PRESS;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= GAP_TH) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= 4'b0000;
      len_q   <= 3'd0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      len_q   <= len_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign code = code_q;
  assign len  = len_q;
  assign err  = err_q;
  assign done = done_q;

endmodule

// File: tb/tb_morse_key_ctrl.sv
// Bench for morse_key_ctrl with DASH=8, GAP=16, DEB=4.
// A letter-level model (queue of elements plus run lengths) predicts outputs
// every cycle; a table of press/release segments adds hand-derived checkpoints.

module tb_morse_key_ctrl;

  localparam int DASH = 8;
  localparam int GAP  = 16;
  localparam int DEB  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key;
  logic [3:0] code;
  logic [2:0] len;
  logic       done;
  logic       err;

  int n_vec = 0;
  int n_bad = 0;
  int seg_dones;

  morse_key_ctrl #(
    .DASH_CYCLES(DASH),
    .GAP_CYCLES (GAP),
    .DEB_CYCLES (DEB),
    .CNT_W      (27)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .key  (key),
    .code (code),
    .len  (len),
    .done (done),
    .err  (err)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: key history -> sampled level -> runs -> element queue.
  // ---------------------------------------------------------------------------
  bit m_km, m_ks, m_kf, m_prev, m_in_letter, m_done;
  int m_dc, m_press_run, m_low_run;
  bit m_elems[$];

  function automatic void model_reset();
    m_km = 0; m_ks = 0; m_kf = 0; m_prev = 0; m_in_letter = 0; m_done = 0;
    m_dc = 0; m_press_run = 0; m_low_run = 0;
    m_elems.delete();
  endfunction

  function automatic void model_step(input bit k, input bit r);
    bit v;
    if (!r) begin
      model_reset();
      return;
    end
`ifdef MORSE_DEBOUNCE_EN
    v = m_kf;
`else
    v = m_ks;
`endif
    m_done = 0;
    if (v) begin
      if (!m_in_letter) begin
        m_elems.delete();
        m_in_letter = 1;
      end
      m_press_run = m_prev ? m_press_run + 1 : 1;
    end else if (m_in_letter) begin
      if (m_prev) begin
        m_elems.push_back(m_press_run >= DASH);
        m_low_run = 1;
      end else begin
        m_low_run++;
      end
      if (m_low_run == GAP) begin
        m_done = 1;
        m_in_letter = 0;
      end
    end
    m_prev = v;
    // stability filter on the synchronized level
    if (m_ks != m_kf) begin
      m_dc++;
      if (m_dc == DEB) begin
        m_kf = m_ks;
        m_dc = 0;
      end
    end else begin
      m_dc = 0;
    end
    m_ks = m_km;
    m_km = k;
  endfunction

  function automatic void model_expect(output logic [3:0] c, output logic [2:0] l, output logic e);
    int n;
    n = m_elems.size();
    c = 4'b0000;
    for (int i = 0; i < n && i < 4; i++) c[i] = m_elems[i];
    l = (n > 4) ? 3'd0 : 3'(n);
    e = (n > 4);
  endfunction

  task automatic check_model();
    logic [3:0] ec;
    logic [2:0] el;
    logic       ee;
    model_expect(ec, el, ee);
    n_vec++;
    if (code !== ec || len !== el || err !== ee || done !== m_done) begin
      n_bad++;
      $display("FAIL model t=%0t: got code=%b len=%0d err=%b done=%b, want code=%b len=%0d err=%b done=%b",
               $time, code, len, err, done, ec, el, ee, m_done);
    end
  endtask

  // Drive one cycle: inputs change 1 time unit after an edge, outputs are
  // sampled 1 time unit after the next edge.
  task automatic cycle(input logic k, input logic r);
    key   = k;
    rst_n = r;
    @(posedge clk);
    model_step(k, r);
    #1;
    if (done === 1'b1) seg_dones++;
    check_model();
  endtask

  task automatic segment(input int p, input int r);
    for (int i = 0; i < p; i++) cycle(1'b1, 1'b1);
    for (int i = 0; i < r; i++) cycle(1'b0, 1'b1);
  endtask

  task automatic check_fixed(input string name, input logic [3:0] ec, input logic [2:0] el,
                             input logic ee, input int ed);
    n_vec++;
    if (code !== ec || len !== el || err !== ee || seg_dones != ed) begin
      n_bad++;
      $display("FAIL %s: got code=%b len=%0d err=%b dones=%0d, want code=%b len=%0d err=%b dones=%0d",
               name, code, len, err, seg_dones, ec, el, ee, ed);
    end
  endtask

  typedef struct {
    int         p;
    int         r;
    logic [3:0] code;
    logic [2:0] len;
    logic       err;
    int         dones;
  } vec_t;

  vec_t tbl[21];

  initial begin
    // press p, release r; expected outputs at the end of the segment and
    // number of done pulses seen inside it (key->FSM latency is 2 cycles)
    tbl[0]  = '{3, 20, 4'b0000, 3'd1, 1'b0, 1};  // E
    tbl[1]  = '{10, 5, 4'b0001, 3'd1, 1'b0, 0};  // N: dash
    tbl[2]  = '{3, 20, 4'b0001, 3'd2, 1'b0, 1};  // N: dot, letter ends
    tbl[3]  = '{10, 5, 4'b0001, 3'd1, 1'b0, 0};  // B
    tbl[4]  = '{3, 5, 4'b0001, 3'd2, 1'b0, 0};
    tbl[5]  = '{3, 5, 4'b0001, 3'd3, 1'b0, 0};
    tbl[6]  = '{3, 20, 4'b0001, 3'd4, 1'b0, 1};
    tbl[7]  = '{4, 0, 4'b0000, 3'd0, 1'b0, 0};   // new press clears before first element
    tbl[8]  = '{3, 20, 4'b0000, 3'd1, 1'b0, 1};  // total press 7 -> dot
    tbl[9]  = '{8, 20, 4'b0001, 3'd1, 1'b0, 1};  // press 8 -> dash
    tbl[10] = '{3, 15, 4'b0000, 3'd1, 1'b0, 0};  // gap 15 follows
    tbl[11] = '{3, 16, 4'b0000, 3'd2, 1'b0, 0};  // same letter; gap 16 follows
    tbl[12] = '{10, 20, 4'b0001, 3'd1, 1'b0, 2}; // done for old letter, then new
    tbl[13] = '{3, 5, 4'b0000, 3'd1, 1'b0, 0};   // overflow run
    tbl[14] = '{3, 5, 4'b0000, 3'd2, 1'b0, 0};
    tbl[15] = '{3, 5, 4'b0000, 3'd3, 1'b0, 0};
    tbl[16] = '{3, 5, 4'b0000, 3'd4, 1'b0, 0};
    tbl[17] = '{3, 5, 4'b0000, 3'd0, 1'b1, 0};   // fifth element
    tbl[18] = '{3, 20, 4'b0000, 3'd0, 1'b1, 1};  // sixth, err holds, done
    tbl[19] = '{4, 0, 4'b0000, 3'd0, 1'b0, 0};   // press from IDLE clears err
    tbl[20] = '{4, 20, 4'b0001, 3'd1, 1'b0, 1};  // total 8 -> dash

    model_reset();
    key   = 1'b0;
    rst_n = 1'b0;
    seg_dones = 0;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
    check_fixed("reset", 4'b0000, 3'd0, 1'b0, 0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);

    for (int i = 0; i < 21; i++) begin
      seg_dones = 0;
      segment(tbl[i].p, tbl[i].r);
`ifndef MORSE_DEBOUNCE_EN
      check_fixed($sformatf("row%0d", i), tbl[i].code, tbl[i].len, tbl[i].err, tbl[i].dones);
`endif
    end

    // Reset in the middle of a press abandons the letter.
    seg_dones = 0;
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    check_fixed("reset_mid_press", 4'b0000, 3'd0, 1'b0, 0);
    for (int i = 0; i < 30; i++) cycle(1'b0, 1'b1);
    check_fixed("no_done_after_reset", 4'b0000, 3'd0, 1'b0, 0);

    // Key held through reset release: a fresh 9-cycle press -> dash.
    seg_dones = 0;
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    segment(9, 30);
    check_fixed("held_through_reset", 4'b0001, 3'd1, 1'b0, 1);

    // 3-cycle glitch.
    seg_dones = 0;
    segment(3, 30);
`ifdef MORSE_DEBOUNCE_EN
    check_fixed("glitch", 4'b0001, 3'd1, 1'b0, 0);
`else
    check_fixed("glitch", 4'b0000, 3'd1, 1'b0, 1);
`endif

    // Randomized letters, occasionally interrupted by reset.
    for (int s = 0; s < 200; s++) begin
      if ($urandom_range(0, 19) == 0) cycle(1'(($urandom_range(0, 1))), 1'b0);
      segment($urandom_range(1, 12), $urandom_range(1, 24));
    end
    segment(0, 40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
